lda_ctrl: RTL
=============

# lda_ctrl

Control FSM for the line-drawing (Bresenham) datapath. It accepts a draw request through a start/ready handshake and sequences the datapath's load, steep-swap, order-swap, parameter, init and per-pixel update strobes. Each pixel is presented to the framebuffer writer through a valid/ready handshake, and completion is signalled with a one-cycle done pulse. It sits between the drawing command source and the datapath/framebuffer.

## Interface
- CNT_W, 10, width of the emitted-pixel counter.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk.
- i_start  in  1  draw request; accepted only in IDLE.
- i_abort  in  1  abandon the current line; ignored in IDLE.
- i_x_past_end  in  1  from datapath: the current registered x is greater than x1 (combinational on datapath registers).
- i_plot_ready  in  1  framebuffer writer accepts the current pixel.
- o_ready  out  1  high in IDLE only.
- o_busy  out  1  the inverse of o_ready.
- o_done  out  1  one-cycle pulse in the DONE state.
- o_plot  out  1  pixel valid; the datapath x/y outputs are the pixel.
- o_set_x0x1y0y1  out  1  datapath: load endpoints.
- o_set_steep  out  1  datapath: swap axes if steep.
- o_set_x0gtx1  out  1  datapath: swap endpoints if x0>x1.
- o_set_params  out  1  datapath: latch deltax/deltay/ystep.
- o_init  out  1  datapath: x=x0, y=y0, error=-deltax/2.
- o_upd_err  out  1  datapath: error += deltay.
- o_upd_xy  out  1  datapath: x++, conditional y step / error correction.
- o_npix  out  CNT_W  pixels accepted in the current or last line.

## Operation
- Moore FSM with one-hot-decodable outputs. Each strobe is high for exactly one cycle, in its own state only.
- IDLE: o_ready=1. If i_start=1, go to LOAD.
- LOAD: o_set_x0x1y0y1=1, o_npix cleared. Go to STEEP.
- STEEP: o_set_steep=1. Go to ORDER.
- ORDER: o_set_x0gtx1=1. Go to PARAMS.
- PARAMS: o_set_params=1. Go to INIT.
- INIT: o_init=1. Go to CHECK.
- CHECK: no strobes. If i_x_past_end=1, go to DONE; otherwise go to PLOT.
- PLOT: o_plot=1, held until i_plot_ready=1. On handshake, go to UPD_ERR and increment o_npix. o_npix saturates at all-ones.
- UPD_ERR: o_upd_err=1. Go to UPD_XY.
- UPD_XY: o_upd_xy=1. Go to CHECK.
- DONE: o_done=1. Go to IDLE.
- i_abort=1 in any state other than IDLE forces IDLE on the next edge, with no o_done. Abort has priority over all other transitions.
- Abort in PLOT with i_plot_ready=1 in the same cycle: the pixel counts (o_npix increments) and the next state is IDLE.
- i_start outside IDLE is ignored and not queued.
- The caller holds the endpoint coordinates stable from the i_start acceptance cycle through the LOAD cycle.
- o_npix holds its value after DONE or abort until the next LOAD.

## Timing
- Reset: state=IDLE, o_ready=1, o_busy=0, o_npix=0, all strobes, o_plot and o_done = 0.
- Reset asserted mid-line: IDLE on the next edge, no o_done, o_npix=0. Reset has priority over i_abort and i_start.
- Let the acceptance edge be cycle 0, with the FSM in LOAD during cycle 1.
- Setup: LOAD..INIT occupy cycles 1–5. The first CHECK is in cycle 6.
- Per pixel with i_plot_ready held high: 4 cycles (CHECK, PLOT, UPD_ERR, UPD_XY). Each cycle of backpressure adds 1.
- A line of N pixels with no backpressure: o_plot in cycles 6+4k+1 for k=0..N-1. The final CHECK is in cycle 6+4N, o_done in cycle 7+4N, and o_ready=1 in cycle 8+4N.
- i_x_past_end is sampled only in CHECK. It must be valid one cycle after o_init or o_upd_xy.

## Test plan
- Horizontal line, bench models i_x_past_end for x0=0,x1=3, i_plot_ready=1, start at cycle 0 -> o_plot in cycles 7,11,15,19; o_done in cycle 23; o_npix=4; strobe order LOAD,STEEP,ORDER,PARAMS,INIT is one cycle each in cycles 1–5.
- Single point (x0=x1=5) -> one o_plot in cycle 7; o_done in cycle 11; o_npix=1.
- Backpressure: i_plot_ready=0 for 3 cycles on the 2nd pixel of the 4-pixel line -> o_plot held for 4 cycles; no o_upd_err/o_upd_xy during the stall; o_done in cycle 26; o_npix=4.
- i_start pulsed in cycles 3 and 12 during a line -> ignored; exactly one o_done; o_ready stays 0 until after DONE.
- i_abort in PLOT of pixel 3 with i_plot_ready=1 -> IDLE next cycle; no o_done; o_npix=3. A new start then draws normally with o_npix restarting from 0.
- i_reset in cycle 9 of a line -> all outputs at reset values from cycle 10; no o_done; the next start behaves as in scenario 1.

Source files
------------

// File: rtl/lda_ctrl.sv
// ---------------------------------------------------------------------------
// lda_ctrl - control FSM for the Bresenham line-drawing datapath.
//
// Accepts a draw request through a start/ready handshake, then steps the
// datapath through endpoint load, steep swap, order swap, parameter latch and
// init. After that it loops CHECK -> PLOT -> UPD_ERR -> UPD_XY until the
// datapath reports x past the end point. Each pixel goes to the framebuffer
// writer through a valid/ready handshake, and the line ends with a one-cycle
// done pulse.
//
// Ports:
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_start             draw request, accepted only in IDLE
//   i_abort             abandon the current line (ignored in IDLE)
//   i_x_past_end        datapath: registered x is beyond x1
//   i_plot_ready        framebuffer writer accepts the current pixel
//   o_ready / o_busy    idle indication and its inverse
//   o_done              one-cycle end-of-line pulse
//   o_plot              pixel valid
//   o_set_x0x1y0y1, o_set_steep, o_set_x0gtx1, o_set_params, o_init,
//   o_upd_err, o_upd_xy datapath strobes, one per state
//   o_npix              pixels accepted in the current or last line
// ---------------------------------------------------------------------------
module lda_ctrl #(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_x_past_end,
    input  logic             i_plot_ready,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_plot,
    output logic             o_set_x0x1y0y1,
    output logic             o_set_steep,
    output logic             o_set_x0gtx1,
    output logic             o_set_params,
    output logic             o_init,
    output logic             o_upd_err,
    output logic             o_upd_xy,
    output logic [CNT_W-1:0] o_npix
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD    = 4'd1;
    localparam logic [3:0] S_STEEP   = 4'd2;
    localparam logic [3:0] S_ORDER   = 4'd3;
    localparam logic [3:0] S_PARAMS  = 4'd4;
    localparam logic [3:0] S_INIT    = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_PLOT    = 4'd7;
    localparam logic [3:0] S_UPD_ERR = 4'd8;
    localparam logic [3:0] S_UPD_XY  = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [CNT_W-1:0] npix;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (i_start) state_next = S_LOAD;
            S_LOAD:    state_next = S_STEEP;
            S_STEEP:   state_next = S_ORDER;
            S_ORDER:   state_next = S_PARAMS;
            S_PARAMS:  state_next = S_INIT;
            S_INIT:    state_next = S_CHECK;
            S_CHECK:   state_next = i_x_past_end ? S_DONE : S_PLOT;
            S_PLOT:    if (i_plot_ready) state_next = S_UPD_ERR;
            S_UPD_ERR: state_next = S_UPD_XY;
            S_UPD_XY:  state_next = S_CHECK;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        // Abort overrides every other transition once a line is in progress.
        if (i_abort && (state != S_IDLE)) state_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_next;
    end

    // Counter is cleared as the request is accepted so it already reads zero
    // during LOAD. A pixel handshaken in the same cycle as an abort still
    // counts, because the writer has taken it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            npix <= '0;
        end else if ((state == S_IDLE) && i_start) begin
            npix <= '0;
        end else if ((state == S_PLOT) && i_plot_ready && (npix != '1)) begin
            npix <= npix + CNT_W'(1);
        end
    end

    assign o_ready        = (state == S_IDLE);
    assign o_busy         = (state != S_IDLE);
    assign o_done         = (state == S_DONE);
    assign o_plot         = (state == S_PLOT);
    assign o_set_x0x1y0y1 = (state == S_LOAD);
    assign o_set_steep    = (state == S_STEEP);
    assign o_set_x0gtx1   = (state == S_ORDER);
    assign o_set_params   = (state == S_PARAMS);
    assign o_init         = (state == S_INIT);
    assign o_upd_err      = (state == S_UPD_ERR);
    assign o_upd_xy       = (state == S_UPD_XY);
    assign o_npix         = npix;

endmodule
